pulse_sync_rx_mc: RTL

//  Destination-domain receiver for N toggle-encoded pulse channels arriving from a foreign clock domain.

---
 rtl/pulse_sync_pkg.sv | 29 ++
 rtl/pulse_sync_rx_mc_if.sv | 13 +
 rtl/pulse_sync_chain.sv | 23 ++
 rtl/pulse_sync_rx_mc.sv | 116 +++++++++++
 4 files changed

// File: rtl/pulse_sync_pkg.sv
// Shared constants and the round-robin pick helper for the pulse_sync_rx_mc receiver.
package pulse_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int NCH_DEF         = 4;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 4;
  localparam int NCH_MAX         = 32;

  // First set bit of mask at or above ptr, wrapping modulo nch; 0 if mask is empty.
  function automatic int unsigned rr_pick(input logic [NCH_MAX-1:0] mask,
                                          input int unsigned        ptr,
                                          input int unsigned        nch);
    int unsigned idx;
    logic        found;
    rr_pick = 0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NCH_MAX; i++) begin
      if (i < nch && !found) begin
        idx = (ptr + i) % nch;
        if (mask[idx[4:0]]) begin
          rr_pick = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/pulse_sync_rx_mc_if.sv
// Event handshake bus between the pulse receiver (master) and its consumer (slave).
interface pulse_sync_rx_mc_if #(
  parameter int NCH = 4
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           evt_valid_o;
  logic           evt_ready_i;
  logic [CHW-1:0] evt_ch_o;

  modport master (output evt_valid_o, output evt_ch_o, input  evt_ready_i);
  modport slave  (input  evt_valid_o, input  evt_ch_o, output evt_ready_i);
endinterface

// File: rtl/pulse_sync_chain.sv
// Single-bit multi-flop synchroniser with synchronous active-high reset.
module pulse_sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d_i};

  // NOTE: flops use non-blocking assignment so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_sync_rx_mc.sv
// Multi-channel toggle-pulse receiver: sync, edge detect, saturating pending counters, RR drain.
// Optional sticky overflow flags are built when PULSE_RX_OVF_EN is defined.
module pulse_sync_rx_mc
  import pulse_sync_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NCH-1:0]     tgl_i,
  pulse_sync_rx_mc_if.master evt
`ifdef PULSE_RX_OVF_EN
  ,
  output logic [NCH-1:0]     ovf_o,
  input  logic [NCH-1:0]     ovf_clr_i
`endif
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [CNT_W-1:0] cnt_t;

  logic [NCH-1:0]     sync_s, dly_q, dly_d, edge_det, dec;
  cnt_t               pend_q [NCH];
  cnt_t               pend_d [NCH];
  logic               valid_q, valid_d;
  logic [CHW-1:0]     ch_q, ch_d, rr_q, rr_d, winner;
  logic [NCH_MAX-1:0] pend_mask;
  logic               load, any_pend;
`ifdef PULSE_RX_OVF_EN
  logic [NCH-1:0]     ovf_q, ovf_d;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_sync
    pulse_sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (tgl_i[c]),
      .q_o   (sync_s[c])
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dly_d     = sync_s;
    edge_det  = sync_s ^ dly_q;
    pend_mask = '0;
    for (int c = 0; c < NCH; c++) pend_mask[c] = (pend_q[c] != '0);
    any_pend  = |pend_mask;
    winner    = CHW'(rr_pick(pend_mask, 32'(rr_q), NCH));
    load      = !valid_q || evt.evt_ready_i;

    valid_d = valid_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    dec     = '0;
    if (load) begin
      if (any_pend) begin
        valid_d     = 1'b1;
        ch_d        = winner;
        rr_d        = (winner == CHW'(NCH - 1)) ? '0 : winner + 1'b1;
        dec[winner] = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end

    // Increment and decrement together cancel, even at saturation.
    for (int c = 0; c < NCH; c++) begin
      pend_d[c] = pend_q[c];
      if (edge_det[c] && dec[c])              pend_d[c] = pend_q[c];
      else if (edge_det[c] && pend_q[c] != CNT_MAX) pend_d[c] = pend_q[c] + 1'b1;
      else if (dec[c])                        pend_d[c] = pend_q[c] - 1'b1;
    end

`ifdef PULSE_RX_OVF_EN
    for (int c = 0; c < NCH; c++) begin
      ovf_d[c] = (edge_det[c] && pend_q[c] == CNT_MAX && !dec[c]) ||
                 (ovf_q[c] && !ovf_clr_i[c]);
    end
`endif
  end

  // NOTE: the pending counters are ordinary flops, so they are cleared by reset like the rest of the state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dly_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      rr_q    <= '0;
      for (int c = 0; c < NCH; c++) pend_q[c] <= '0;
`ifdef PULSE_RX_OVF_EN
      ovf_q   <= '0;
`endif
    end else begin
      dly_q   <= dly_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      for (int c = 0; c < NCH; c++) pend_q[c] <= pend_d[c];
`ifdef PULSE_RX_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign evt.evt_valid_o = valid_q;
  assign evt.evt_ch_o    = ch_q;
`ifdef PULSE_RX_OVF_EN
  assign ovf_o = ovf_q;
`endif

endmodule
